// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline <-> hazard-unit signal bundle for hazard_ctrl_mc.
// master: pipeline side (drives register addresses and memory status).
// slave:  hazard unit (drives stalls, flushes, forwarding selects, timeout).
interface hazard_ctrl_mc_if #(
  parameter int unsigned RA_W = 5
);
  logic [RA_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic            RegWriteM, RegWriteW;
  logic            ResultSrcE;
  logic [1:0]      PCSrcE;
  logic            MemReqM, MemAckM;
  logic            StallF, StallD, StallE, StallM;
  logic            FlushD, FlushE, FlushW;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeout
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for a 5-stage pipeline with a multi-cycle data memory.
// Handles E-stage forwarding, load-use stalls, branch/jump flushes and
// memory-wait stalls with a sticky timeout.
// Optional macro HAZARD_PERF_CNT_EN adds saturating load-use / memory-stall
// cycle counters on PerfLwStall and PerfMemStall.
module hazard_ctrl_mc #(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_ctrl_mc_if.slave      hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          PerfLwStall,
  output logic [31:0]          PerfMemStall
`endif
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_WAIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StRun, StWait, StErr} stateT;

  stateT           stateQ, stateD;
  logic [CntW-1:0] waitCntQ, waitCntD;
  logic            memTimeoutQ;
  logic            memStall;
  logic            lwStall;
  logic            redirect;

  logic [RA_W-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;

  assign rs1D = hz.Rs1D;
  assign rs2D = hz.Rs2D;
  assign rs1E = hz.Rs1E;
  assign rs2E = hz.Rs2E;
  assign rdE  = hz.RdE;
  assign rdM  = hz.RdM;
  assign rdW  = hz.RdW;

  // M-stage result has priority over W since it is the younger write.
  function automatic logic [1:0] fwdSel(input logic [RA_W-1:0] rs, input logic [RA_W-1:0] dM,
                                        input logic [RA_W-1:0] dW, input logic wrM,
                                        input logic wrW);
    if (wrM && rs == dM && rs != '0) begin
      return 2'b10;
    end else if (wrW && rs == dW && rs != '0) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  // Forwarding selects for both E-stage operands.
  always_comb begin
    hz.ForwardAE = fwdSel(rs1E, rdM, rdW, hz.RegWriteM, hz.RegWriteW);
    hz.ForwardBE = fwdSel(rs2E, rdM, rdW, hz.RegWriteM, hz.RegWriteW);
  end

  // Load-use detection and control-flow redirect decode (11 behaves as sequential).
  always_comb begin
    lwStall  = hz.ResultSrcE && (rs1D == rdE || rs2D == rdE) && rdE != '0;
    redirect = (hz.PCSrcE == 2'b01) || (hz.PCSrcE == 2'b10);
  end

  // Memory-wait FSM next state, wait counter and combinational memStall.
  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    memStall = 1'b0;
    unique case (stateQ)
      StRun: begin
        waitCntD = '0;
        if (hz.MemReqM && !hz.MemAckM) begin
          memStall = 1'b1;
          stateD   = StWait;
        end
      end
      StWait: begin
        if (hz.MemAckM) begin
          stateD = StRun;
        end else begin
          memStall = 1'b1;
          if (waitCntQ != MaxCnt) begin
            waitCntD = waitCntQ + CntW'(1);
          end
          // The counter reaches MAX_WAIT on this edge: give up.
          if (waitCntQ == LastCnt) begin
            stateD = StErr;
          end
        end
      end
      StErr: begin
        memStall = 1'b1;
      end
      default: begin
        stateD = StRun;
      end
    endcase
  end

  // Stall/flush steering; a memory stall freezes everything and only bubbles W.
  always_comb begin
    hz.StallF = lwStall;
    hz.StallD = lwStall;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = redirect;
    hz.FlushE = lwStall | redirect;
    hz.FlushW = 1'b0;
    if (memStall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushD = 1'b0;
      hz.FlushE = 1'b0;
      hz.FlushW = 1'b1;
    end
  end

  assign hz.MemTimeout = memTimeoutQ;

  // State, wait counter and registered timeout flag (mirrors state == ERR).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ      <= StRun;
      waitCntQ    <= '0;
      memTimeoutQ <= 1'b0;
    end else begin
      stateQ      <= stateD;
      waitCntQ    <= waitCntD;
      memTimeoutQ <= (stateD == StErr);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfLwQ, perfMemQ;

  // Saturating stall-cycle counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perfLwQ  <= '0;
      perfMemQ <= '0;
    end else begin
      if (lwStall && perfLwQ != '1) begin
        perfLwQ <= perfLwQ + 32'd1;
      end
      if (memStall && perfMemQ != '1) begin
        perfMemQ <= perfMemQ + 32'd1;
      end
    end
  end

  assign PerfLwStall  = perfLwQ;
  assign PerfMemStall = perfMemQ;
`endif

endmodule
